instr_mem_loader: RTL and testbench

Instruction memory serving the fetch stage's `address`/`data` read port, with a byte-stream programming port that loads a program image while holding the core in reset. Sits between the fetch stage and an external loader such as a UART bridge. It is the responder end of the fetch interface: fetch drives a byte address and this block returns the 32-bit instruction word in the same cycle.

---
 rtl/instr_mem_loader.sv | 111 +++++++++++
 tb/tb_instr_mem_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Instruction memory with a combinational fetch port and a little-endian byte-stream loader.
// While a load session runs, the core is held in reset and fetch sees NOP_WORD.
module instr_mem_loader #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
   localparam int         ADDR_W      = $clog2(DEPTH_WORDS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_data,
   input  logic              prog_start,
   input  logic              prog_valid,
   input  logic [7:0]        prog_byte,
   output logic              prog_ready,
   input  logic              prog_done,
   output logic [ADDR_W:0]   prog_words,
   output logic              prog_overflow,
   output logic              core_reset_n
);

   typedef enum logic {RUN, LOAD} state_t;

   localparam logic [ADDR_W:0] DEPTH_CNT = DEPTH_WORDS[ADDR_W:0];
   localparam logic [ADDR_W:0] PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};

   state_t          state;
   logic [1:0]      byte_cnt;
   logic [ADDR_W:0] word_ptr;
   logic [31:0]     staging;
   logic [31:0]     mem [DEPTH_WORDS];

   logic            accept;
   logic [31:0]     fill;
   logic [1:0]      cnt_next;
   logic            word_full;
   logic            wr_req;
   logic [31:0]     wr_word;
   logic            ptr_full;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^fetch_addr[1:0];

   // cnt_next wraps to 0 on the 4th byte, so a done with a just-completed word writes nothing extra
   always_comb begin
      accept    = prog_valid && prog_ready;
      fill      = staging;
      if (accept) fill[{byte_cnt, 3'b000} +: 8] = prog_byte;
      cnt_next  = accept ? byte_cnt + 2'd1 : byte_cnt;
      word_full = accept && (byte_cnt == 2'd3);
      wr_req    = reset_n && (state == LOAD) &&
                  (word_full || (prog_done && (cnt_next != 2'd0)));
      ptr_full  = (word_ptr == DEPTH_CNT);
      case (cnt_next)
         2'd1:    wr_word = {24'd0, fill[7:0]};
         2'd2:    wr_word = {16'd0, fill[15:0]};
         2'd3:    wr_word = {8'd0, fill[23:0]};
         default: wr_word = fill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (accept) staging <= fill;
      if (wr_req && !ptr_full) mem[word_ptr[ADDR_W-1:0]] <= wr_word;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= RUN;
         core_reset_n  <= 1'b0;
         prog_ready    <= 1'b0;
         word_ptr      <= '0;
         byte_cnt      <= 2'd0;
         prog_overflow <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (prog_start) begin
                  state         <= LOAD;
                  prog_ready    <= 1'b1;
                  core_reset_n  <= 1'b0;
                  word_ptr      <= '0;
                  byte_cnt      <= 2'd0;
                  prog_overflow <= 1'b0;
               end else begin
                  core_reset_n  <= 1'b1;
               end
            end
            LOAD: begin
               byte_cnt <= prog_done ? 2'd0 : cnt_next;
               if (wr_req) begin
                  if (ptr_full) prog_overflow <= 1'b1;
                  else          word_ptr      <= word_ptr + PTR_ONE;
               end
               // core_reset_n stays low here and is released by RUN one edge later
               if (prog_done) begin
                  state      <= RUN;
                  prog_ready <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   assign prog_words = word_ptr;

   assign fetch_data = ((state == LOAD) || (fetch_addr[31:ADDR_W+2] != '0)) ?
                       NOP_WORD : mem[fetch_addr[ADDR_W+1:2]];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized bench for instr_mem_loader: two instances (1024 and 4 words) share one stimulus
// stream and are compared every cycle against a session-level reference model.
module tb_instr_mem_loader;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] fetch_addr;
   logic        prog_start, prog_valid, prog_done;
   logic [7:0]  prog_byte;

   logic [31:0] fetch_data_big, fetch_data_small;
   logic        prog_ready_big, prog_ready_small;
   logic [10:0] prog_words_big;
   logic [2:0]  prog_words_small;
   logic        prog_overflow_big, prog_overflow_small;
   logic        core_reset_n_big, core_reset_n_small;

   int checks = 0;
   int failures = 0;
   bit rand_fetch = 0;

   // reference model: session byte list, run/load flag, word images known to be written
   bit          loading = 0;
   bit          core_m = 0;
   logic [7:0]  sess_q[$];
   logic [31:0] mref_big[1024];
   bit          known_big[1024];
   logic [31:0] mref_small[4];
   bit          known_small[4];

   always #10 clk = ~clk;

   instr_mem_loader #(.DEPTH_WORDS(1024), .NOP_WORD(NOP)) u_big (
      .clk(clk), .reset_n(reset_n), .fetch_addr(fetch_addr), .fetch_data(fetch_data_big),
      .prog_start(prog_start), .prog_valid(prog_valid), .prog_byte(prog_byte),
      .prog_ready(prog_ready_big), .prog_done(prog_done), .prog_words(prog_words_big),
      .prog_overflow(prog_overflow_big), .core_reset_n(core_reset_n_big));

   instr_mem_loader #(.DEPTH_WORDS(4), .NOP_WORD(NOP)) u_small (
      .clk(clk), .reset_n(reset_n), .fetch_addr(fetch_addr), .fetch_data(fetch_data_small),
      .prog_start(prog_start), .prog_valid(prog_valid), .prog_byte(prog_byte),
      .prog_ready(prog_ready_small), .prog_done(prog_done), .prog_words(prog_words_small),
      .prog_overflow(prog_overflow_small), .core_reset_n(core_reset_n_small));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void commit(input int nw);
      for (int i = 0; i < nw; i++) begin
         logic [31:0] w;
         w = '0;
         for (int b = 0; b < 4; b++)
            if (4 * i + b < sess_q.size()) w[8*b +: 8] = sess_q[4*i+b];
         if (i < 1024) begin mref_big[i] = w; known_big[i] = 1'b1; end
         if (i < 4)    begin mref_small[i] = w; known_small[i] = 1'b1; end
      end
   endfunction

   function automatic void model_edge();
      if (!reset_n) begin
         if (loading) commit(sess_q.size() / 4);
         loading = 0;
         core_m  = 0;
         sess_q.delete();
      end else if (!loading) begin
         if (prog_start) begin
            loading = 1;
            core_m  = 0;
            sess_q.delete();
         end else begin
            core_m = 1;
         end
      end else begin
         if (prog_valid) sess_q.push_back(prog_byte);
         if (prog_done) begin
            commit((sess_q.size() + 3) / 4);
            loading = 0;
         end
      end
   endfunction

   function automatic int words_raw();
      return loading ? sess_q.size() / 4 : (sess_q.size() + 3) / 4;
   endfunction

   function automatic int words_sat(input int depth);
      return (words_raw() > depth) ? depth : words_raw();
   endfunction

   function automatic bit exp_fetch(input int depth, input logic [31:0] addr,
                                    output logic [31:0] w);
      logic [31:0] widx;
      widx = addr >> 2;
      w = NOP;
      if (loading || widx >= 32'(depth)) return 1'b1;
      if (depth == 1024) begin
         w = mref_big[widx[9:0]];
         return known_big[widx[9:0]];
      end
      w = mref_small[widx[1:0]];
      return known_small[widx[1:0]];
   endfunction

   task automatic compare_all(input string tag);
      logic [31:0] e;
      chk({tag, " ready_big"},   32'(prog_ready_big),      32'(loading));
      chk({tag, " ready_small"}, 32'(prog_ready_small),    32'(loading));
      chk({tag, " core_big"},    32'(core_reset_n_big),    32'(core_m));
      chk({tag, " core_small"},  32'(core_reset_n_small),  32'(core_m));
      chk({tag, " words_big"},   32'(prog_words_big),      32'(words_sat(1024)));
      chk({tag, " words_small"}, 32'(prog_words_small),    32'(words_sat(4)));
      chk({tag, " ovf_big"},     32'(prog_overflow_big),   32'(words_raw() > 1024));
      chk({tag, " ovf_small"},   32'(prog_overflow_small), 32'(words_raw() > 4));
      if (exp_fetch(1024, fetch_addr, e)) chk({tag, " fetch_big"}, fetch_data_big, e);
      if (exp_fetch(4, fetch_addr, e))    chk({tag, " fetch_small"}, fetch_data_small, e);
   endtask

   task automatic cyc(input string tag);
      if (rand_fetch)
         fetch_addr = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 40));
      model_edge();
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic peek(input string tag, input logic [31:0] addr,
                       input logic [31:0] exp_big, input logic [31:0] exp_small);
      fetch_addr = addr;
      #1;
      chk({tag, " big"}, fetch_data_big, exp_big);
      chk({tag, " small"}, fetch_data_small, exp_small);
   endtask

   task automatic start_sess();
      prog_start = 1'b1;
      cyc("start");
      prog_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input bit done);
      prog_valid = 1'b1;
      prog_byte  = b;
      prog_done  = done;
      cyc("byte");
      prog_valid = 1'b0;
      prog_done  = 1'b0;
   endtask

   task automatic end_sess();
      prog_done = 1'b1;
      cyc("done");
      prog_done = 1'b0;
   endtask

   initial begin
      logic [7:0] img [8];
      img = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
      reset_n = 1'b0; prog_start = 1'b0; prog_valid = 1'b0; prog_done = 1'b0;
      prog_byte = 8'h00; fetch_addr = 32'h0;

      repeat (3) cyc("reset");
      chk("rst core", 32'(core_reset_n_big), 32'd0);
      chk("rst ready", 32'(prog_ready_big), 32'd0);
      reset_n = 1'b1;
      cyc("release");
      chk("release core", 32'(core_reset_n_big), 32'd1);
      peek("oor fetch", 32'h0000_1000, NOP, NOP);

      start_sess();
      for (int i = 0; i < 8; i++) send(img[i], 1'b0);
      end_sess();
      chk("two words", 32'(prog_words_big), 32'd2);
      peek("w0", 32'h0, 32'h00A0_0513, 32'h00A0_0513);
      peek("w1", 32'h4, 32'h0010_0593, 32'h0010_0593);
      peek("w1 misaligned", 32'h6, 32'h0010_0593, 32'h0010_0593);

      start_sess();
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b1);
      chk("partial words", 32'(prog_words_big), 32'd1);
      chk("partial core held", 32'(core_reset_n_big), 32'd0);
      peek("partial w0", 32'h0, 32'h00CC_BBAA, 32'h00CC_BBAA);
      cyc("idle");
      chk("partial core release", 32'(core_reset_n_big), 32'd1);

      start_sess();
      for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
      end_sess();
      chk("ovf words_small", 32'(prog_words_small), 32'd4);
      chk("ovf flag_small", 32'(prog_overflow_small), 32'd1);
      chk("ovf words_big", 32'(prog_words_big), 32'd5);
      peek("ovf w0", 32'h0, 32'h0302_0100, 32'h0302_0100);
      peek("ovf w1", 32'h4, 32'h0706_0504, 32'h0706_0504);
      cyc("idle");
      peek("ovf w2", 32'h8, 32'h0B0A_0908, 32'h0B0A_0908);
      peek("ovf w3", 32'hC, 32'h0F0E_0D0C, 32'h0F0E_0D0C);
      peek("ovf w4", 32'h10, 32'h1312_1110, NOP);
      start_sess();
      chk("ovf cleared", 32'(prog_overflow_small), 32'd0);
      end_sess();

      start_sess();
      for (int i = 0; i < 6; i++) send(8'(8'h11 + i), 1'b0);
      reset_n = 1'b0;
      cyc("rst mid");
      chk("rst mid ready", 32'(prog_ready_big), 32'd0);
      chk("rst mid words", 32'(prog_words_big), 32'd0);
      reset_n = 1'b1;
      cyc("idle");
      peek("rst mid w0", 32'h0, 32'h1413_1211, 32'h1413_1211);
      peek("rst mid w1", 32'h4, 32'h0706_0504, 32'h0706_0504);
      prog_done = 1'b1;
      cyc("stray done");
      prog_done = 1'b0;
      peek("stray done w1", 32'h4, 32'h0706_0504, 32'h0706_0504);
      chk("stray done ready", 32'(prog_ready_big), 32'd0);

      prog_valid = 1'b1; prog_byte = 8'hFF;
      cyc("stray valid");
      prog_valid = 1'b0;
      peek("stray valid w0", 32'h0, 32'h1413_1211, 32'h1413_1211);
      chk("stray valid words", 32'(prog_words_big), 32'd0);
      start_sess();
      for (int i = 0; i < 4; i++) send(8'(8'h21 + i), 1'b0);
      prog_start = 1'b1;
      cyc("restart in load");
      prog_start = 1'b0;
      for (int i = 0; i < 4; i++) send(8'(8'h25 + i), 1'b0);
      end_sess();
      chk("restart words", 32'(prog_words_big), 32'd2);
      peek("restart w0", 32'h0, 32'h2423_2221, 32'h2423_2221);
      peek("restart w1", 32'h4, 32'h2827_2625, 32'h2827_2625);

      rand_fetch = 1;
      for (int c = 0; c < 3000; c++) begin
         reset_n    = ($urandom_range(0, 199) != 0);
         prog_start = ($urandom_range(0, 19) == 0);
         prog_done  = ($urandom_range(0, 24) == 0);
         prog_valid = 1'($urandom_range(0, 1));
         prog_byte  = 8'($urandom());
         cyc("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
